wb_write_arbiter: RTL

WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_aux_fifo.sv | 59 +++++
 rtl/wb_write_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared widths, aux entry type and helpers for the writeback arbiter.
package wb_pkg;
   localparam int WB_ADDR_W    = 5;
   localparam int WB_DATA_W    = 32;
   localparam int WB_AUX_DEPTH = 2;
   localparam int WB_CNT_W     = 2;
   localparam int WB_NREGS     = 1 << WB_ADDR_W;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_aux_entry_t;

   function automatic logic [WB_NREGS-1:0] wb_onehot(input logic [WB_ADDR_W-1:0] a);
      logic [WB_NREGS-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      return v;
   endfunction
endpackage

// File: rtl/wb_aux_fifo.sv
// Two-entry aux result FIFO; entry 0 is always the head.
module wb_aux_fifo
   import wb_pkg::*;
(
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    i_push,
   input  wb_aux_entry_t                           i_push_entry,
   input  logic                                    i_pop,
   output logic [WB_CNT_W-1:0]                     o_count,
   output wb_aux_entry_t                           o_head,
   output logic [WB_AUX_DEPTH-1:0]                 o_valid,
   output logic [WB_AUX_DEPTH-1:0][WB_ADDR_W-1:0]  o_addr
);
   logic [WB_CNT_W-1:0] r_count;
   wb_aux_entry_t       r_ent [WB_AUX_DEPTH];
   logic                w_pop;
   logic                w_push;

   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && ((r_count < WB_CNT_W'(WB_AUX_DEPTH)) || w_pop);

   // Shift-style storage: pop moves entry 1 down, push lands behind the survivors.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= '0;
         r_ent[0] <= '0;
         r_ent[1] <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == '0) r_ent[0] <= i_push_entry;
               else               r_ent[1] <= i_push_entry;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_ent[0] <= r_ent[1];
               r_count  <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_ent[0] <= i_push_entry;
               end else begin
                  r_ent[0] <= r_ent[1];
                  r_ent[1] <= i_push_entry;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_count    = r_count;
   assign o_head     = r_ent[0];
   assign o_valid[0] = (r_count >= 2'd1);
   assign o_valid[1] = (r_count >= 2'd2);
   assign o_addr[0]  = r_ent[0].addr;
   assign o_addr[1]  = r_ent[1].addr;
endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: the pipeline has priority, buffered
// mult/div results fill idle slots, and a starve counter forces a bubble.
module wb_write_arbiter
   import wb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pipe_we,
   input  logic [WB_ADDR_W-1:0]  pipe_waddr,
   input  logic [WB_DATA_W-1:0]  pipe_wdata,
   input  logic                  aux_valid,
   input  logic [WB_ADDR_W-1:0]  aux_addr,
   input  logic [WB_DATA_W-1:0]  aux_data,
   output logic                  aux_ready,
   output logic                  rf_we,
   output logic [WB_ADDR_W-1:0]  rf_waddr,
   output logic [WB_DATA_W-1:0]  rf_wdata,
   output logic                  stall_req,
   output logic [WB_NREGS-1:0]   aux_pending
);
   logic [WB_CNT_W-1:0]                    w_count;
   wb_aux_entry_t                          w_head;
   wb_aux_entry_t                          w_push_entry;
   logic [WB_AUX_DEPTH-1:0]                w_valid;
   logic [WB_AUX_DEPTH-1:0][WB_ADDR_W-1:0] w_addr;
   logic                                   w_fifo_ne;
   logic                                   w_push;
   logic                                   w_pop;
   logic                                   w_pipe_win;
   logic [3:0]                             w_starve_inc;
   logic [3:0]                             r_starve;
   logic                                   r_stall;
   logic                                   r_rf_we;
   logic [WB_ADDR_W-1:0]                   r_rf_waddr;
   logic [WB_DATA_W-1:0]                   r_rf_wdata;
   logic [WB_NREGS-1:0]                    w_pending;

   assign aux_ready         = (w_count < WB_CNT_W'(WB_AUX_DEPTH));
   assign w_fifo_ne         = (w_count != '0);
   // r0 is hardwired zero, so zero-address results are swallowed here.
   assign w_push            = aux_valid && aux_ready && (aux_addr != '0);
   assign w_push_entry.addr = aux_addr;
   assign w_push_entry.data = aux_data;
   // A pipeline write during a requested bubble loses to the FIFO head.
   assign w_pipe_win        = !r_stall && pipe_we && (pipe_waddr != '0);
   assign w_pop             = !w_pipe_win && w_fifo_ne;
   assign w_starve_inc      = r_starve + 4'd1;

   wb_aux_fifo u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_push),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .o_count      (w_count),
      .o_head       (w_head),
      .o_valid      (w_valid),
      .o_addr       (w_addr)
   );

   // Count pipeline wins that skip a waiting aux entry; request a bubble at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve <= '0;
         r_stall  <= 1'b0;
      end else begin
         r_stall <= 1'b0;
         if (w_pipe_win && w_fifo_ne) begin
            if (w_starve_inc == 4'(STARVE_LIMIT)) begin
               r_stall  <= 1'b1;
               r_starve <= '0;
            end else begin
               r_starve <= w_starve_inc;
            end
         end else begin
            r_starve <= '0;
         end
      end
   end

   // Register the winning write; address/data hold when nobody wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else begin
         r_rf_we <= w_pipe_win || w_pop;
         if (w_pipe_win) begin
            r_rf_waddr <= pipe_waddr;
            r_rf_wdata <= pipe_wdata;
         end else if (w_pop) begin
            r_rf_waddr <= w_head.addr;
            r_rf_wdata <= w_head.data;
         end
      end
   end

   // Scoreboard view of registers with a buffered aux write.
   always_comb begin
      w_pending = '0;
      for (int i = 0; i < WB_AUX_DEPTH; i++) begin
         if (w_valid[i]) w_pending = w_pending | wb_onehot(w_addr[i]);
      end
   end

   assign aux_pending = w_pending;
   assign stall_req   = r_stall;
   assign rf_we       = r_rf_we;
   assign rf_waddr    = r_rf_waddr;
   assign rf_wdata    = r_rf_wdata;
endmodule
